// File: rtl/tanh_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tanh_arbiter
// Purpose  : Round-robin arbiter plus two-stage pipeline sequencer that
//            shares one DIM-lane combinational tanh datapath among NREQ
//            requesters. Stage 1 registers the granted operand and drives the
//            tanh input. Stage 2 registers the tanh result together with the
//            index of the requester that produced it.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req_valid/req_data  - per-requester operand handshake (inputs)
//            req_ready           - one-hot (or zero) acceptance
//            act_in / act_out    - operand to / result from the tanh instance
//            rsp_valid/rsp_ready - response handshake
//            rsp_data / rsp_id   - registered tanh result and its requester
//            busy                - either pipeline stage holds an entry
// Revision : 1.0 - initial release
// ============================================================================
module tanh_arbiter #(
    parameter int NREQ  = 4,
    parameter int DIM   = 4,
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NREQ-1:0]                             req_valid,
    input  logic [NREQ*DIM*WIDTH-1:0]                   req_data,
    output logic [NREQ-1:0]                             req_ready,
    output logic [DIM*WIDTH-1:0]                        act_in,
    input  logic [DIM*WIDTH-1:0]                        act_out,
    output logic                                        rsp_valid,
    input  logic                                        rsp_ready,
    output logic [DIM*WIDTH-1:0]                        rsp_data,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0]  rsp_id,
    output logic                                        busy
);

    localparam int c_IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_VW  = DIM * WIDTH;

    // Reject parameter sets the datapath cannot represent.
    if (NREQ < 2 || NREQ > 8 || FRAC >= WIDTH) begin : g_param_check
        $error("tanh_arbiter: unsupported NREQ/FRAC/WIDTH combination");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              r_s1_valid;
    logic [c_VW-1:0]   r_s1_data;
    logic [c_IDW-1:0]  r_s1_id;
    logic              r_rsp_valid;
    logic [c_VW-1:0]   r_rsp_data;
    logic [c_IDW-1:0]  r_rsp_id;
    logic [c_IDW-1:0]  r_last_id;

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic              w_s2_load;
    logic              w_s1_free;
    logic              w_found;
    logic              w_accept;
    logic [c_IDW-1:0]  w_grant_id;
    logic [NREQ-1:0]   w_grant;

    // Stage 2 takes the stage-1 entry whenever it is empty or draining;
    // stage 1 can refill in the same cycle it hands its entry forward.
    assign w_s2_load = r_s1_valid && (!r_rsp_valid || rsp_ready);
    assign w_s1_free = !r_s1_valid || w_s2_load;

    // (base + offset) mod NREQ for offsets in 1..NREQ.
    function automatic logic [c_IDW-1:0] f_rr_idx(input logic [c_IDW-1:0] base,
                                                  input int               offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return sum[c_IDW-1:0];
    endfunction

    // Round-robin search starting just after the last granted requester.
    // Offset NREQ wraps back to last_id itself so a lone requester can be
    // granted back-to-back.
    always_comb begin
        w_found    = 1'b0;
        w_grant_id = '0;
        w_grant    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && req_valid[f_rr_idx(r_last_id, k)]) begin
                w_found    = 1'b1;
                w_grant_id = f_rr_idx(r_last_id, k);
            end
        end
        // Nothing is granted during reset, even though the state registers
        // still hold pre-reset contents in that cycle.
        if (w_found && w_s1_free && !rst) begin
            w_grant[w_grant_id] = 1'b1;
        end
    end

    assign w_accept = w_found && w_s1_free && !rst;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_id     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_last_id   <= c_IDW'(NREQ - 1);
        end else begin
            // Stage 1: refill on accept, otherwise empty once forwarded.
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_data  <= req_data[int'(w_grant_id)*c_VW +: c_VW];
                r_s1_id    <= w_grant_id;
                r_last_id  <= w_grant_id;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end

            // Stage 2: capture the combinational tanh result of stage 1.
            // A simultaneous drain and load keeps rsp_valid high.
            if (w_s2_load) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= act_out;
                r_rsp_id    <= r_s1_id;
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready = w_grant;
    assign act_in    = r_s1_data;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign busy      = r_s1_valid || r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_tanh_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tanh_arbiter
// Purpose  : Directed self-checking bench for tanh_arbiter. A behavioural
//            tanh stand-in answers act_in combinationally on act_out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tanh_arbiter;

    localparam int NREQ  = 4;
    localparam int DIM   = 4;
    localparam int WIDTH = 16;
    localparam int VW    = DIM * WIDTH;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*VW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [VW-1:0]        act_in;
    logic [VW-1:0]        act_out;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [VW-1:0]        rsp_data;
    logic [1:0]           rsp_id;
    logic                 busy;

    int total;
    int bad;

    tanh_arbiter #(
        .NREQ  (NREQ),
        .DIM   (DIM),
        .WIDTH (WIDTH),
        .FRAC  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .act_in    (act_in),
        .act_out   (act_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared tanh instance: exact Q8.8 values for the
    // directed points, an arbitrary non-identity map elsewhere.
    function automatic logic [15:0] tanh_lane(input logic [15:0] x);
        case (x)
            16'h0000: return 16'h0000;
            16'h0100: return 16'h00C3;
            16'hFF00: return 16'hFF3D;
            16'h0800: return 16'h0100;
            default:  return x ^ 16'h5A5A;
        endcase
    endfunction

    function automatic logic [VW-1:0] tanh_vec(input logic [VW-1:0] x);
        logic [VW-1:0] y;
        y = '0;
        for (int l = 0; l < DIM; l++) begin
            y[l*WIDTH +: WIDTH] = tanh_lane(x[l*WIDTH +: WIDTH]);
        end
        return y;
    endfunction

    function automatic logic [VW-1:0] mkvec(input logic [15:0] base);
        logic [VW-1:0] v;
        v = '0;
        for (int l = 0; l < DIM; l++) begin
            v[l*WIDTH +: WIDTH] = base + 16'(l);
        end
        return v;
    endfunction

    always_comb begin
        act_out = '0;
        act_out = tanh_vec(act_in);
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_edge();
        rst = 1'b1;
        drive_edge();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'hF;
        req_data  = '0;
        rsp_ready = 1'b1;
        drive_edge();
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
        end
        total++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy_valid: got busy=%b rsp_valid=%b expected 0 0", busy, rsp_valid);
        end
        total++;
        if (act_in !== '0 || rsp_data !== '0 || rsp_id !== 2'd0) begin
            bad++;
            $display("FAIL reset_data: got act_in=%h rsp_data=%h rsp_id=%0d expected zeros", act_in, rsp_data, rsp_id);
        end
        drive_edge();
        req_valid = 4'b0000;
        rst       = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got req_ready=%b busy=%b expected 0000 0", req_ready, busy);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single();
        logic [VW-1:0] v;
        v = '0;
        v[15:0] = 16'h0100;
        drive_edge();
        req_valid = 4'b0100;
        req_data[2*VW +: VW] = v;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL single_grant: got %b expected 0100", req_ready);
        end
        drive_edge();
        req_valid = 4'b0000;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1 || act_in !== v) begin
            bad++;
            $display("FAIL single_stage1: got rsp_valid=%b busy=%b act_in=%h expected 0 1 %h", rsp_valid, busy, act_in, v);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 64'h0000_0000_0000_00C3) begin
            bad++;
            $display("FAIL single_rsp: got valid=%b id=%0d data=%h expected 1 2 00000000000000c3", rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_drain: got rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_signed();
        drive_edge();
        req_valid = 4'b0001;
        req_data[0 +: VW] = 64'h0000_0000_0000_FF00;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL signed_grant0: got %b expected 0001", req_ready);
        end
        drive_edge();
        req_data[0 +: VW] = 64'h0000_0000_0000_0800;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL signed_grant1: got %b expected 0001", req_ready);
        end
        drive_edge();
        req_valid = 4'b0000;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 64'h0000_0000_0000_FF3D) begin
            bad++;
            $display("FAIL signed_neg: got valid=%b id=%0d data=%h expected 1 0 000000000000ff3d", rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 64'h0000_0000_0000_0100) begin
            bad++;
            $display("FAIL signed_sat: got valid=%b id=%0d data=%h expected 1 0 0000000000000100", rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL signed_drain: got rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_round_robin();
        logic [NREQ-1:0] exp_rdy;
        logic [1:0]      exp_id;
        do_reset();
        for (int r = 0; r < NREQ; r++) begin
            req_data[r*VW +: VW] = mkvec(16'h1000 + 16'(r*16));
        end
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 8) begin
                exp_rdy = 4'b0001 << (i % 4);
                total++;
                if (req_ready !== exp_rdy) begin
                    bad++;
                    $display("FAIL rr_grant[%0d]: got %b expected %b", i, req_ready, exp_rdy);
                end
            end
            if (i >= 2) begin
                exp_id = 2'((i - 2) % 4);
                total++;
                if (rsp_valid !== 1'b1 || rsp_id !== exp_id ||
                    rsp_data !== tanh_vec(mkvec(16'h1000 + 16'(exp_id)*16'd16))) begin
                    bad++;
                    $display("FAIL rr_rsp[%0d]: got valid=%b id=%0d data=%h expected 1 %0d", i, rsp_valid, rsp_id, rsp_data, exp_id);
                end
            end
            drive_edge();
            if (i == 7) begin
                req_valid = 4'b0000;
            end
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rr_drain: got rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure();
        int            accepts;
        int            seq;
        int            nrsp;
        logic [VW-1:0] held_act;
        logic [VW-1:0] held_rsp;
        accepts = 0;
        seq     = 0;
        nrsp    = 0;
        held_act = '0;
        held_rsp = '0;
        drive_edge();
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        req_data[1*VW +: VW] = mkvec(16'h3000);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c < 2) begin
                total++;
                if (req_ready !== 4'b0010) begin
                    bad++;
                    $display("FAIL bp_grant[%0d]: got %b expected 0010", c, req_ready);
                end
            end else begin
                total++;
                if (req_ready !== 4'b0000) begin
                    bad++;
                    $display("FAIL bp_stall[%0d]: got %b expected 0000", c, req_ready);
                end
                if (c == 2) begin
                    held_act = act_in;
                    held_rsp = rsp_data;
                end else begin
                    total++;
                    if (act_in !== held_act || rsp_data !== held_rsp || rsp_valid !== 1'b1) begin
                        bad++;
                        $display("FAIL bp_hold[%0d]: got act_in=%h rsp_data=%h expected %h %h", c, act_in, rsp_data, held_act, held_rsp);
                    end
                end
            end
            if ((req_valid & req_ready) != 4'b0000) begin
                accepts++;
            end
            drive_edge();
            if (c < 2) begin
                seq++;
                req_data[1*VW +: VW] = mkvec(16'h3000 + 16'(seq*16));
            end
        end
        total++;
        if (accepts != 2 || held_rsp !== tanh_vec(mkvec(16'h3000))) begin
            bad++;
            $display("FAIL bp_accepts: got %0d accepts rsp=%h expected 2 %h", accepts, held_rsp, tanh_vec(mkvec(16'h3000)));
        end
        rsp_ready = 1'b1;
        for (int c = 5; c < 10; c++) begin
            @(negedge clk);
            if (c == 5) begin
                total++;
                if (req_ready !== 4'b0010) begin
                    bad++;
                    $display("FAIL bp_no_bubble: got %b expected 0010", req_ready);
                end
            end
            if (rsp_valid === 1'b1) begin
                total++;
                if (nrsp > 2 || rsp_id !== 2'd1 ||
                    rsp_data !== tanh_vec(mkvec(16'h3000 + 16'(nrsp*16)))) begin
                    bad++;
                    $display("FAIL bp_order[%0d]: got id=%0d data=%h expected 1 %h", nrsp, rsp_id, rsp_data, tanh_vec(mkvec(16'h3000 + 16'(nrsp*16))));
                end
                nrsp++;
            end
            drive_edge();
            req_valid = 4'b0000;
        end
        total++;
        if (nrsp != 3) begin
            bad++;
            $display("FAIL bp_count: got %0d responses expected 3", nrsp);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_pointer_hold();
        drive_edge();
        req_valid = 4'b1000;
        req_data[3*VW +: VW] = mkvec(16'h4000);
        req_data[0 +: VW]    = mkvec(16'h5000);
        @(negedge clk);
        total++;
        if (req_ready !== 4'b1000) begin
            bad++;
            $display("FAIL ptr_grant3: got %b expected 1000", req_ready);
        end
        drive_edge();
        req_valid = 4'b0000;
        repeat (3) drive_edge();
        req_valid = 4'b1001;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL ptr_hold: got %b expected 0001", req_ready);
        end
        drive_edge();
        req_valid = 4'b1000;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b1000) begin
            bad++;
            $display("FAIL ptr_next: got %b expected 1000", req_ready);
        end
        drive_edge();
        req_valid = 4'b0000;
        repeat (3) drive_edge();
    endtask

    // ------------------------------------------------------------------
    task automatic test_mid_reset();
        drive_edge();
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        req_data[2*VW +: VW] = mkvec(16'h6000);
        drive_edge();
        drive_edge();
        req_valid = 4'b1110;
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL mr_full: got busy=%b rsp_valid=%b req_ready=%b expected 1 1 0000", busy, rsp_valid, req_ready);
        end
        drive_edge();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL mr_rst_ready: got %b expected 0000", req_ready);
        end
        drive_edge();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== '0 || act_in !== '0) begin
            bad++;
            $display("FAIL mr_cleared: got rsp_valid=%b busy=%b rsp_data=%h act_in=%h expected 0 0 0 0", rsp_valid, busy, rsp_data, act_in);
        end
        total++;
        if (req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL mr_first_grant: got %b expected 0010", req_ready);
        end
        drive_edge();
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        repeat (3) drive_edge();
    endtask

    // ------------------------------------------------------------------
    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_signed();
        test_round_robin();
        test_backpressure();
        test_pointer_hold();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
